// File: rtl/avm_pkg.sv
// avm_pkg: shared FSM states, response codes and defaults for the avm_* Avalon-MM blocks.
package avm_pkg;

    typedef enum logic [1:0] {
        IDLE,
        XFER,
        RESP
    } state_e;

    localparam logic RSP_OK      = 1'b0;
    localparam logic RSP_TIMEOUT = 1'b1;

    localparam int DEF_TIMEOUT = 256;

endpackage

// File: rtl/avm_cmd_master.sv
// avm_cmd_master: command-stream to single Avalon-MM read/write transfers with waitrequest timeout.
module avm_cmd_master
    import avm_pkg::*;
#(
    parameter int ADDR_W  = 4,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] avm_m0_address,
    output logic              avm_m0_read,
    output logic              avm_m0_write,
    output logic [DATA_W-1:0] avm_m0_writedata,
    input  logic [DATA_W-1:0] avm_m0_readdata,
    input  logic              avm_m0_waitrequest
);

    localparam int CNT_W = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
    // Abort fires on the wait edge that would bring the counter to TIMEOUT.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              cmd_ready_q, cmd_ready_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              rd_q, rd_d, wr_q, wr_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;
    logic              timeout_hit;

    assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cmd_ready_d = cmd_ready_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rd_d        = rd_q;
        wr_d        = wr_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            IDLE: begin
                cmd_ready_d = 1'b1;
                if (cmd_valid && cmd_ready_q) begin
                    state_d     = XFER;
                    cmd_ready_d = 1'b0;
                    cnt_d       = '0;
                    addr_d      = cmd_addr;
                    wdata_d     = cmd_write ? cmd_wdata : '0;
                    rd_d        = !cmd_write;
                    wr_d        = cmd_write;
                end
            end
            XFER: begin
                if (!avm_m0_waitrequest || timeout_hit) begin
                    state_d     = RESP;
                    rd_d        = 1'b0;
                    wr_d        = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = avm_m0_waitrequest ? RSP_TIMEOUT : RSP_OK;
                    rsp_rdata_d = (rd_q && !avm_m0_waitrequest) ? avm_m0_readdata : '0;
                end else begin
                    cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d     = IDLE;
                    cmd_ready_d = 1'b1;
                    rsp_valid_d = 1'b0;
                    rsp_err_d   = RSP_OK;
                    rsp_rdata_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            cmd_ready_q <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rd_q        <= 1'b0;
            wr_q        <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cmd_ready_q <= cmd_ready_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rd_q        <= rd_d;
            wr_q        <= wr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign cmd_ready        = cmd_ready_q;
    assign rsp_valid        = rsp_valid_q;
    assign rsp_rdata        = rsp_rdata_q;
    assign rsp_err          = rsp_err_q;
    assign avm_m0_address   = addr_q;
    assign avm_m0_read      = rd_q;
    assign avm_m0_write     = wr_q;
    assign avm_m0_writedata = wdata_q;

endmodule

// File: tb/tb_avm_cmd_master.sv
// tb_avm_cmd_master: directed and random commands against a slave model with planned wait counts.
module tb_avm_cmd_master;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_write = 1'b0;
    logic [3:0]  cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic        rsp_ready = 1'b0;
    logic [31:0] avm_m0_readdata = '0;
    logic        avm_m0_waitrequest = 1'b0;
    logic        cmd_ready, rsp_valid, rsp_err;
    logic [31:0] rsp_rdata, avm_m0_writedata;
    logic [3:0]  avm_m0_address;
    logic        avm_m0_read, avm_m0_write;

    int passed = 0;
    int total = 0;

    avm_cmd_master #(.ADDR_W(4), .DATA_W(32), .TIMEOUT(TO)) dut (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .avm_m0_address(avm_m0_address), .avm_m0_read(avm_m0_read), .avm_m0_write(avm_m0_write),
        .avm_m0_writedata(avm_m0_writedata), .avm_m0_readdata(avm_m0_readdata),
        .avm_m0_waitrequest(avm_m0_waitrequest)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Slave stalls for `waits` edges; the model derives strobe length and response from that alone.
    task automatic do_cmd(input bit w, input logic [3:0] a, input logic [31:0] d,
                          input int waits, input logic [31:0] rd, input int hold);
        bit          exp_err;
        int          busy;
        logic [31:0] exp_rd;
        exp_err = (waits >= TO);
        busy    = exp_err ? TO : waits + 1;
        exp_rd  = (exp_err || w) ? 32'h0 : rd;
        chk("cmd_ready_idle", 32'(cmd_ready), 1);
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        step;
        cmd_valid = 1'b0;
        cmd_write = 1'($urandom);
        cmd_addr  = 4'($urandom);
        cmd_wdata = $urandom;
        for (int c = 0; c < busy; c++) begin
            chk("rd_strobe", 32'(avm_m0_read), 32'(!w));
            chk("wr_strobe", 32'(avm_m0_write), 32'(w));
            chk("address", 32'(avm_m0_address), 32'(a));
            if (w) chk("writedata", avm_m0_writedata, d);
            chk("rsp_valid_busy", 32'(rsp_valid), 0);
            chk("cmd_ready_busy", 32'(cmd_ready), 0);
            avm_m0_waitrequest = (c < waits);
            avm_m0_readdata    = (c < waits) ? $urandom : rd;
            step;
        end
        avm_m0_waitrequest = 1'b0;
        for (int c = 0; c <= hold; c++) begin
            chk("rd_after", 32'(avm_m0_read), 0);
            chk("wr_after", 32'(avm_m0_write), 0);
            chk("rsp_valid", 32'(rsp_valid), 1);
            chk("rsp_err", 32'(rsp_err), 32'(exp_err));
            chk("rsp_rdata", rsp_rdata, exp_rd);
            chk("cmd_ready_resp", 32'(cmd_ready), 0);
            rsp_ready = (c == hold);
            cmd_valid = 1'b1;
            cmd_write = 1'($urandom);
            step;
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b0;
        chk("rsp_valid_drop", 32'(rsp_valid), 0);
        chk("cmd_ready_back", 32'(cmd_ready), 1);
        chk("no_strobe", 32'(avm_m0_read | avm_m0_write), 0);
    endtask

    initial begin
        step;
        step;
        chk("rst_cmd_ready", 32'(cmd_ready), 0);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_rsp_err", 32'(rsp_err), 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_address", 32'(avm_m0_address), 0);
        chk("rst_read", 32'(avm_m0_read), 0);
        chk("rst_write", 32'(avm_m0_write), 0);
        chk("rst_writedata", avm_m0_writedata, 0);
        reset_n = 1'b1;
        step;
        chk("ready_after_rst", 32'(cmd_ready), 1);

        do_cmd(1'b1, 4'd1, 32'h55, 0, 32'h1234_5678, 0);
        do_cmd(1'b0, 4'd4, 32'h0, 3, 32'hDEAD_BEEF, 0);
        do_cmd(1'b0, 4'd2, 32'h0, 20, 32'hCAFE_F00D, 1);
        do_cmd(1'b1, 4'd5, 32'hA5A5_0001, 0, 32'h0, 0);
        do_cmd(1'b0, 4'd7, 32'h0, TO - 1, 32'h0BAD_CAFE, 0);
        do_cmd(1'b0, 4'd8, 32'h0, TO, 32'h1111_2222, 0);
        do_cmd(1'b1, 4'd9, 32'h7777_8888, TO, 32'h0, 2);
        do_cmd(1'b0, 4'd6, 32'h0, 1, 32'h600D_D00D, 5);

        chk("ready_pre_reset", 32'(cmd_ready), 1);
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 4'd3;
        avm_m0_waitrequest = 1'b1;
        step;
        cmd_valid = 1'b0;
        chk("xfer_read", 32'(avm_m0_read), 1);
        step;
        chk("xfer_read_held", 32'(avm_m0_read), 1);
        #2 reset_n = 1'b0;
        #1;
        chk("async_read_drop", 32'(avm_m0_read), 0);
        chk("async_write_low", 32'(avm_m0_write), 0);
        chk("async_rsp_valid", 32'(rsp_valid), 0);
        chk("async_cmd_ready", 32'(cmd_ready), 0);
        step;
        step;
        chk("rst_no_rsp", 32'(rsp_valid), 0);
        avm_m0_waitrequest = 1'b0;
        reset_n = 1'b1;
        step;
        chk("ready_after_rst2", 32'(cmd_ready), 1);
        chk("no_rsp_after_rst", 32'(rsp_valid), 0);

        do_cmd(1'b1, 4'd10, 32'h0102_0304, 0, 32'h0, 0);
        do_cmd(1'b0, 4'd11, 32'h0, 0, 32'h5566_7788, 0);

        for (int i = 0; i < 24; i++)
            do_cmd(1'($urandom), 4'($urandom), $urandom, int'($urandom_range(10, 0)),
                   $urandom, int'($urandom_range(3, 0)));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
